// File: rtl/a_logic_pkg.sv
// Shared types and the reduction helper for the bundled-data logic join.
// Contents:
//   op_e         run-time operator encoding (XOR, AND, OR, XNOR)
//   ch_state_e   per-channel operand holder state
//   main_state_e output-side sequencer state
//   reduce()     one result bit from one bit-column of all captured operands
package a_logic_pkg;

    // Upper bound on channel count supported by reduce().
    localparam int MAX_K = 32;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_XNOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        DONE  = 2'd2
    } ch_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        REQ   = 2'd2,
        RTZ   = 2'd3
    } main_state_e;

    // Reduce bit i of every channel (bits[0..k-1]) to one result bit.
    // Bits at or above k are ignored. XNOR is the inverted XOR reduction.
    function automatic logic reduce(op_e op, logic [MAX_K-1:0] bits, int k);
        logic acc;
        acc = (op == OP_AND);
        for (int i = 0; i < MAX_K; i++) begin
            if (i < k) begin
                case (op)
                    OP_AND:  acc = acc & bits[i];
                    OP_OR:   acc = acc | bits[i];
                    default: acc = acc ^ bits[i];
                endcase
            end
        end
        if (op == OP_XNOR) acc = ~acc;
        return acc;
    endfunction

endpackage

// File: rtl/a_sync.sv
// Multi-flop synchroniser for one asynchronous handshake line.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-low reset; every stage resets to RST_VAL
//   d_i  in   asynchronous input
//   q_o  out  synchronised output (SYNC edges of latency)
module a_sync #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC-1:0] stg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_q <= {SYNC{RST_VAL}};
        end else begin
            stg_q <= {stg_q[SYNC-2:0], d_i};
        end
    end

    assign q_o = stg_q[SYNC-1];

endmodule

// File: rtl/a_logic_join.sv
// K-input four-phase bundled-data join with a selectable bitwise reduction.
// Each input channel is captured independently; once every channel holds an
// operand the reduced result is registered on d_o and offered on r_o after
// T cycles.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset
//   r_i   in   [K]    per-channel request (idle level Rpol)
//   a_i   out  [K]    per-channel acknowledge
//   d_i   in   [K*N]  channel k data at d_i[k*N +: N]
//   op    in   [2]    0 XOR, 1 AND, 2 OR, 3 XNOR; sampled on the load edge
//   r_o   out         output request
//   a_o   in          output acknowledge
//   d_o   out  [N]    registered result
//   busy  out         high from load until the return to IDLE
//
// Main FSM states:
//   state | meaning
//   IDLE  | collecting operands; load d_o once every channel is captured
//   DELAY | result loaded, counting down before raising r_o
//   REQ   | r_o active, waiting for synchronised a_o active
//   RTZ   | r_o idle, waiting for a_o idle and every channel DONE
// Channel states:
//   EMPTY | no operand; capture on synchronised request
//   HELD  | operand latched and acknowledged; waiting for request release
//   DONE  | operand kept, request ignored until the main FSM clears it
module a_logic_join
    import a_logic_pkg::*;
#(
    parameter int   K    = 2,
    parameter int   N    = 1,
    parameter logic Rpol = 1'b0,
    parameter int   T    = 2,
    parameter int   SYNC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [K-1:0]   r_i,
    output logic [K-1:0]   a_i,
    input  logic [K*N-1:0] d_i,
    input  logic [1:0]     op,
    output logic           r_o,
    input  logic           a_o,
    output logic [N-1:0]   d_o,
    output logic           busy
);

    logic [K-1:0] r_s;
    logic         a_o_s;

    for (genvar g = 0; g < K; g++) begin : g_rsync
        a_sync #(.SYNC(SYNC), .RST_VAL(Rpol)) u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (r_i[g]),
            .q_o (r_s[g])
        );
    end

    a_sync #(.SYNC(SYNC), .RST_VAL(Rpol)) u_ao_sync (
        .clk (clk),
        .rst (rst),
        .d_i (a_o),
        .q_o (a_o_s)
    );

    // Handshake levels normalised so that 1 means "active".
    logic [K-1:0] r_act;
    logic         a_o_act;
    assign r_act   = r_s ^ {K{Rpol}};
    assign a_o_act = a_o_s ^ Rpol;

    ch_state_e   ch_q  [K];
    logic [N-1:0] dat_q [K];
    logic [K-1:0] a_i_q;
    main_state_e st_q;
    logic [7:0]  cnt_q;
    logic        r_o_q;
    logic [N-1:0] d_o_q;
    logic        busy_q;

    logic         joined;
    logic         all_done;
    logic [N-1:0] red_d;
    logic [MAX_K-1:0] col;

    always_comb begin
        joined   = 1'b1;
        all_done = 1'b1;
        for (int k = 0; k < K; k++) begin
            if (ch_q[k] == EMPTY) joined   = 1'b0;
            if (ch_q[k] != DONE)  all_done = 1'b0;
        end
    end

    // Reduce column by column: bit b of the result combines bit b of every
    // captured operand, so there is no interaction between bit positions.
    always_comb begin
        red_d = '0;
        col   = '0;
        for (int b = 0; b < N; b++) begin
            col = '0;
            for (int k = 0; k < K; k++) begin
                col[k] = dat_q[k][b];
            end
            red_d[b] = reduce(op_e'(op), col, K);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < K; k++) begin
                ch_q[k]  <= EMPTY;
                dat_q[k] <= '0;
            end
            a_i_q  <= {K{Rpol}};
            st_q   <= IDLE;
            cnt_q  <= 8'd0;
            r_o_q  <= Rpol;
            d_o_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int k = 0; k < K; k++) begin
                case (ch_q[k])
                    EMPTY: if (r_act[k]) begin
                        dat_q[k] <= d_i[k*N +: N];
                        a_i_q[k] <= ~Rpol;
                        ch_q[k]  <= HELD;
                    end
                    HELD: if (!r_act[k]) begin
                        a_i_q[k] <= Rpol;
                        ch_q[k]  <= DONE;
                    end
                    default: ;
                endcase
            end

            case (st_q)
                IDLE: if (joined) begin
                    d_o_q  <= red_d;
                    busy_q <= 1'b1;
                    if (T == 0) begin
                        r_o_q <= ~Rpol;
                        st_q  <= REQ;
                    end else begin
                        // Counter reaches zero T-1 edges later; r_o rises on the edge after.
                        cnt_q <= 8'(T - 1);
                        st_q  <= DELAY;
                    end
                end
                DELAY: begin
                    if (cnt_q == 8'd0) begin
                        r_o_q <= ~Rpol;
                        st_q  <= REQ;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                REQ: if (a_o_act) begin
                    r_o_q <= Rpol;
                    st_q  <= RTZ;
                end
                RTZ: if (!a_o_act && all_done) begin
                    // Clearing here overrides the channel update above; a
                    // pending re-request is only captured on the next edge.
                    for (int k = 0; k < K; k++) begin
                        ch_q[k] <= EMPTY;
                    end
                    busy_q <= 1'b0;
                    st_q   <= IDLE;
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    assign a_i  = a_i_q;
    assign r_o  = r_o_q;
    assign d_o  = d_o_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_a_logic_join.sv
module tb_a_logic_join;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance 0: K=3, N=8, Rpol=0, T=2
    logic [2:0]  r0;
    logic [2:0]  a0;
    logic [23:0] d0;
    logic [1:0]  op0;
    logic        ro0;
    logic        ao0;
    logic [7:0]  do0;
    logic        busy0;

    // Instance 1: K=2, N=4, Rpol=1, T=0
    logic [1:0]  r1;
    logic [1:0]  a1;
    logic [7:0]  d1;
    logic [1:0]  op1;
    logic        ro1;
    logic        ao1;
    logic [3:0]  do1;
    logic        busy1;

    a_logic_join #(.K(3), .N(8), .Rpol(1'b0), .T(2), .SYNC(2)) u0 (
        .clk(clk), .rst(rst_n), .r_i(r0), .a_i(a0), .d_i(d0), .op(op0),
        .r_o(ro0), .a_o(ao0), .d_o(do0), .busy(busy0)
    );

    a_logic_join #(.K(2), .N(4), .Rpol(1'b1), .T(0), .SYNC(2)) u1 (
        .clk(clk), .rst(rst_n), .r_i(r1), .a_i(a1), .d_i(d1), .op(op1),
        .r_o(ro1), .a_o(ao1), .d_o(do1), .busy(busy1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected handshake timing for instance 0: a request is seen after two
    // synchroniser flops and captured on the third edge; load follows on the
    // next edge; r_o follows T=2 edges after load.
    localparam int CAP_LAT = 3;
    localparam int T0 = 2;

    // Per-transaction observations (cycle indices relative to transaction start)
    int ai_rise[3];
    int ai_fall[3];
    int load_cyc, ro_cyc, busy_fall_cyc, ao_rel_cyc;
    logic [7:0] load_val;
    int glitch, early_idle, timeout, rereq_early;

    function automatic logic [7:0] model3(input int opc, input logic [7:0] a, b, c);
        case (opc)
            0:       return a ^ b ^ c;
            1:       return a & b & c;
            2:       return a | b | c;
            default: return ~(a ^ b ^ c);
        endcase
    endfunction

    // Acts as three channel senders and the output receiver for instance 0.
    // Must be called right after a falling clock edge.
    task automatic txn0(input int opc, input logic [7:0] v0, v1, v2,
                        input int s0, s1, s2, input int ack_wait, ack_hold,
                        input int h0, h1, h2, input bit rereq);
        int st[3];
        int hold[3];
        logic [7:0] v[3];
        int ph[3];
        int hc[3];
        int oph, oc, n;
        bit seen_busy, all_fin;
        st[0] = s0; st[1] = s1; st[2] = s2;
        hold[0] = h0; hold[1] = h1; hold[2] = h2;
        v[0] = v0; v[1] = v1; v[2] = v2;
        oph = 0; oc = 0; seen_busy = 0;
        glitch = 0; early_idle = 0; timeout = 0; rereq_early = 0;
        load_cyc = -1; ro_cyc = -1; busy_fall_cyc = -1; ao_rel_cyc = -1;
        load_val = '0;
        op0 = 2'(opc);
        for (int k = 0; k < 3; k++) begin
            ai_rise[k] = -1; ai_fall[k] = -1; hc[k] = 0;
            ph[k] = r0[k] ? 1 : 0;
        end
        for (n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                case (ph[k])
                    0: if (n >= st[k]) begin d0[k*8 +: 8] = v[k]; r0[k] = 1'b1; ph[k] = 1; end
                    1: if (a0[k]) begin ai_rise[k] = n; ph[k] = 2; end
                    2: if (hc[k] >= hold[k]) begin r0[k] = 1'b0; ph[k] = 3; end else hc[k]++;
                    3: if (!a0[k]) begin ai_fall[k] = n; ph[k] = 4; end
                    5: if (a0[k] && busy0) rereq_early++;
                    default: ;
                endcase
            end
            if (rereq && ph[0] == 4 && oph >= 1 && busy0) begin
                d0[7:0] = 8'h11; r0[0] = 1'b1; ph[0] = 5;
            end
            case (oph)
                0: if (ro0) begin ro_cyc = n; oph = 1; oc = 0; end
                1: if (oc >= ack_wait) begin ao0 = 1'b1; oph = 2; oc = 0; end else oc++;
                2: begin
                    oc++;
                    if (oc >= ack_hold && !ro0) begin ao0 = 1'b0; ao_rel_cyc = n; oph = 3; end
                end
                default: ;
            endcase
            if (busy0 && !seen_busy) begin
                seen_busy = 1; load_cyc = n; load_val = do0;
                op0 = 2'(opc) ^ 2'($urandom_range(1, 3));
            end else if (seen_busy && busy0 && do0 !== load_val) begin
                glitch++;
            end
            if (seen_busy && !busy0 && busy_fall_cyc < 0) begin
                busy_fall_cyc = n;
                if (ao0) early_idle++;
                for (int k = 0; k < 3; k++) if (ph[k] != 4 && ph[k] != 5) early_idle++;
            end
            all_fin = seen_busy && !busy0 && (oph == 3);
            for (int k = 0; k < 3; k++) if (ph[k] != 4 && ph[k] != 5) all_fin = 0;
            if (all_fin) break;
            @(negedge clk);
        end
        if (n >= 400) timeout = 1;
    endtask

    task automatic test_reset();
        vectors++; if (a0 !== 3'b000) begin miscompares++; $display("FAIL reset_a0: got %b expected 000", a0); end
        vectors++; if (ro0 !== 1'b0) begin miscompares++; $display("FAIL reset_ro0: got %b expected 0", ro0); end
        vectors++; if (do0 !== 8'h00) begin miscompares++; $display("FAIL reset_do0: got %h expected 00", do0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        vectors++; if (a1 !== 2'b11) begin miscompares++; $display("FAIL reset_a1: got %b expected 11", a1); end
        vectors++; if (ro1 !== 1'b1) begin miscompares++; $display("FAIL reset_ro1: got %b expected 1", ro1); end
        vectors++; if (do1 !== 4'h0) begin miscompares++; $display("FAIL reset_do1: got %h expected 0", do1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    endtask

    task automatic test_simul_xor();
        txn0(0, 8'hA5, 8'h3C, 8'hFF, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL simul_timeout: got %0d expected 0", timeout); end
        vectors++; if (load_val !== 8'h66) begin miscompares++; $display("FAIL simul_dout: got %h expected 66", load_val); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (ai_rise[k] != CAP_LAT) begin miscompares++; $display("FAIL simul_ack_rise%0d: got %0d expected %0d", k, ai_rise[k], CAP_LAT); end
            vectors++; if (ai_fall[k] <= ai_rise[k]) begin miscompares++; $display("FAIL simul_ack_fall%0d: got %0d expected >%0d", k, ai_fall[k], ai_rise[k]); end
        end
        vectors++; if (load_cyc != CAP_LAT + 1) begin miscompares++; $display("FAIL simul_load_cyc: got %0d expected %0d", load_cyc, CAP_LAT + 1); end
        vectors++; if (ro_cyc - load_cyc != T0) begin miscompares++; $display("FAIL simul_ro_delay: got %0d expected %0d", ro_cyc - load_cyc, T0); end
        vectors++; if (glitch != 0) begin miscompares++; $display("FAIL simul_dout_stable: got %0d changes expected 0", glitch); end
        vectors++; if (ro0 !== 1'b0) begin miscompares++; $display("FAIL simul_ro_idle: got %b expected 0", ro0); end
    endtask

    task automatic test_stagger_and();
        txn0(1, 8'hF0, 8'h3C, 8'hFF, 5, 8, 0, 1, 2, 0, 0, 0, 0);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL stagger_timeout: got %0d expected 0", timeout); end
        vectors++; if (load_val !== 8'h30) begin miscompares++; $display("FAIL stagger_dout: got %h expected 30", load_val); end
        vectors++; if (ai_rise[2] != 0 + CAP_LAT) begin miscompares++; $display("FAIL stagger_ack2: got %0d expected %0d", ai_rise[2], CAP_LAT); end
        vectors++; if (ai_rise[0] != 5 + CAP_LAT) begin miscompares++; $display("FAIL stagger_ack0: got %0d expected %0d", ai_rise[0], 5 + CAP_LAT); end
        vectors++; if (ai_rise[1] != 8 + CAP_LAT) begin miscompares++; $display("FAIL stagger_ack1: got %0d expected %0d", ai_rise[1], 8 + CAP_LAT); end
        vectors++; if (load_cyc != 8 + CAP_LAT + 1) begin miscompares++; $display("FAIL stagger_load_cyc: got %0d expected %0d", load_cyc, 8 + CAP_LAT + 1); end
        vectors++; if (ro_cyc - load_cyc != T0) begin miscompares++; $display("FAIL stagger_ro_delay: got %0d expected %0d", ro_cyc - load_cyc, T0); end
        vectors++; if (glitch != 0) begin miscompares++; $display("FAIL stagger_op_change: got %0d changes expected 0", glitch); end
    endtask

    task automatic test_rereq();
        txn0(2, 8'h01, 8'h02, 8'h04, 0, 1, 2, 3, 1, 0, 0, 0, 1);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL rereq_timeout: got %0d expected 0", timeout); end
        vectors++; if (load_val !== 8'h07) begin miscompares++; $display("FAIL rereq_dout: got %h expected 07", load_val); end
        vectors++; if (r0[0] !== 1'b1) begin miscompares++; $display("FAIL rereq_issued: got %b expected 1", r0[0]); end
        vectors++; if (rereq_early != 0) begin miscompares++; $display("FAIL rereq_early_ack: got %0d expected 0", rereq_early); end
        vectors++; if (a0[0] !== 1'b0) begin miscompares++; $display("FAIL rereq_clear_edge: got %b expected 0", a0[0]); end
        @(negedge clk);
        vectors++; if (a0[0] !== 1'b1) begin miscompares++; $display("FAIL rereq_capture_after_idle: got %b expected 1", a0[0]); end
        txn0(0, 8'h11, 8'h22, 8'h44, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL rereq2_timeout: got %0d expected 0", timeout); end
        vectors++; if (load_val !== 8'h77) begin miscompares++; $display("FAIL rereq2_dout: got %h expected 77", load_val); end
        vectors++; if (load_cyc != CAP_LAT + 1) begin miscompares++; $display("FAIL rereq2_load_cyc: got %0d expected %0d", load_cyc, CAP_LAT + 1); end
    endtask

    task automatic test_slow_ack();
        logic [7:0] a, b, c;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        txn0(3, a, b, c, 0, 0, 0, 0, 20, 0, 30, 0, 0);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL slow_timeout: got %0d expected 0", timeout); end
        vectors++; if (load_val !== model3(3, a, b, c)) begin miscompares++; $display("FAIL slow_dout: got %h expected %h", load_val, model3(3, a, b, c)); end
        vectors++; if (early_idle != 0) begin miscompares++; $display("FAIL slow_early_idle: got %0d expected 0", early_idle); end
        vectors++; if (busy_fall_cyc <= ao_rel_cyc) begin miscompares++; $display("FAIL slow_busy_vs_ack: got %0d expected >%0d", busy_fall_cyc, ao_rel_cyc); end
        vectors++; if (busy_fall_cyc <= ai_fall[1]) begin miscompares++; $display("FAIL slow_busy_vs_chan: got %0d expected >%0d", busy_fall_cyc, ai_fall[1]); end
        vectors++; if (glitch != 0) begin miscompares++; $display("FAIL slow_dout_stable: got %0d changes expected 0", glitch); end
    endtask

    task automatic test_reset_mid();
        int i;
        logic [7:0] a, b, c;
        d0 = {8'hFF, 8'h3C, 8'hA5}; op0 = 2'd0; r0 = 3'b111;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy0) break;
        end
        vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL rstmid_reach_delay: got %b expected 1", busy0); end
        vectors++; if (do0 !== 8'h66) begin miscompares++; $display("FAIL rstmid_pre_dout: got %h expected 66", do0); end
        vectors++; if (a0 !== 3'b111) begin miscompares++; $display("FAIL rstmid_pre_ack: got %b expected 111", a0); end
        rst_n = 1'b0;
        #1;
        vectors++; if (ro0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_ro: got %b expected 0", ro0); end
        vectors++; if (a0 !== 3'b000) begin miscompares++; $display("FAIL rstmid_ack: got %b expected 000", a0); end
        vectors++; if (do0 !== 8'h00) begin miscompares++; $display("FAIL rstmid_dout: got %h expected 00", do0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
        r0 = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        txn0(2, a, b, c, 1, 0, 2, 1, 1, 0, 0, 0, 0);
        vectors++; if (timeout != 0) begin miscompares++; $display("FAIL rstmid_fresh_timeout: got %0d expected 0", timeout); end
        vectors++; if (load_val !== model3(2, a, b, c)) begin miscompares++; $display("FAIL rstmid_fresh_dout: got %h expected %h", load_val, model3(2, a, b, c)); end
        vectors++; if (ro_cyc - load_cyc != T0) begin miscompares++; $display("FAIL rstmid_fresh_ro_delay: got %0d expected %0d", ro_cyc - load_cyc, T0); end
    endtask

    task automatic test_rpol1_xnor();
        int i;
        d1 = {4'h3, 4'h5}; op1 = 2'd3;
        r1 = 2'b00;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a1 === 2'b00) break;
        end
        vectors++; if (a1 !== 2'b00) begin miscompares++; $display("FAIL rpol_ack_active: got %b expected 00", a1); end
        r1 = 2'b11;
        for (i = 0; i < 50; i++) begin
            if (busy1) break;
            @(negedge clk);
        end
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL rpol_busy: got %b expected 1", busy1); end
        vectors++; if (do1 !== 4'h9) begin miscompares++; $display("FAIL rpol_dout: got %h expected 9", do1); end
        vectors++; if (ro1 !== 1'b0) begin miscompares++; $display("FAIL rpol_ro_on_load: got %b expected 0", ro1); end
        op1 = 2'd1;
        ao1 = 1'b0;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ro1) break;
        end
        vectors++; if (ro1 !== 1'b1) begin miscompares++; $display("FAIL rpol_ro_release: got %b expected 1", ro1); end
        ao1 = 1'b1;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy1) break;
        end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rpol_busy_end: got %b expected 0", busy1); end
        vectors++; if (a1 !== 2'b11) begin miscompares++; $display("FAIL rpol_ack_idle: got %b expected 11", a1); end
        vectors++; if (do1 !== 4'h9) begin miscompares++; $display("FAIL rpol_dout_hold: got %h expected 9", do1); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, c;
        int opc, s0, s1, s2, smax;
        for (int it = 0; it < 8; it++) begin
            opc = int'($urandom_range(0, 3));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            s0 = int'($urandom_range(0, 6)); s1 = int'($urandom_range(0, 6)); s2 = int'($urandom_range(0, 6));
            smax = s0; if (s1 > smax) smax = s1; if (s2 > smax) smax = s2;
            txn0(opc, a, b, c, s0, s1, s2, int'($urandom_range(0, 4)), int'($urandom_range(1, 5)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0);
            vectors++; if (timeout != 0) begin miscompares++; $display("FAIL rand%0d_timeout: got %0d expected 0", it, timeout); end
            vectors++; if (load_val !== model3(opc, a, b, c)) begin miscompares++; $display("FAIL rand%0d_dout op%0d: got %h expected %h", it, opc, load_val, model3(opc, a, b, c)); end
            vectors++; if (load_cyc != smax + CAP_LAT + 1) begin miscompares++; $display("FAIL rand%0d_load_cyc: got %0d expected %0d", it, load_cyc, smax + CAP_LAT + 1); end
            vectors++; if (ro_cyc - load_cyc != T0) begin miscompares++; $display("FAIL rand%0d_ro_delay: got %0d expected %0d", it, ro_cyc - load_cyc, T0); end
            vectors++; if (glitch != 0 || early_idle != 0) begin miscompares++; $display("FAIL rand%0d_protocol: got glitch=%0d early=%0d expected 0", it, glitch, early_idle); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        r0 = '0; d0 = '0; op0 = '0; ao0 = 1'b0;
        r1 = 2'b11; d1 = '0; op1 = '0; ao1 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_simul_xor();
        test_stagger_and();
        test_rereq();
        test_slow_ack();
        test_reset_mid();
        test_rpol1_xnor();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/a_logic_join.md
Name: a_logic_join

Overview:
- Clocked, parametrised successor to the two-input bundled-data XOR.
- Joins K four-phase bundled-data input channels and captures each operand independently as it arrives.
- Applies a run-time-selectable bitwise reduction (XOR/AND/OR/XNOR) and issues the registered result on one output channel after a programmable delay.
- Sits on clocked islands of the async fabric, between combine/fork stages.

Parameters:
- K, 2: number of input channels (>=2).
- N, 1: data width per channel.
- Rpol, 1'b0: idle (reset) level of every req/ack line; active level is ~Rpol.
- T, 2: cycles from d_o load to r_o active (0..255).
- SYNC, 2: synchroniser flops on each r_i and on a_o (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- r_i  in  K  per-channel request
- a_i  out  K  per-channel acknowledge
- d_i  in  K*N  channel k data at d_i[k*N +: N], stable while r_i[k] active
- op  in  2  0 XOR, 1 AND, 2 OR, 3 XNOR; sampled at join completion
- r_o  out  1  output request
- a_o  in  1  output acknowledge
- d_o  out  N  result, stable while r_o active
- busy  out  1  high from join completion until return to IDLE

Behaviour:
- Reset (rst low, async): a_i = {K{Rpol}}, r_o = Rpol, d_o = 0, busy = 0, all channels EMPTY, FSM IDLE, delay counter 0.
- Synchronisation:
  - r_i[k] and a_o pass through SYNC flops before use.
  - All decisions use the synchronised values.
  - d_i is captured only on the edge where synchronised r_i[k] is first seen active.
- Per-channel FSM:
  - EMPTY: on synced r_i[k] active, latch data, go HELD; a_i[k] goes active at that edge.
  - HELD: on synced r_i[k] idle, a_i[k] goes idle, go DONE.
  - DONE: holds data and ignores r_i[k] until the main FSM clears it.
  - A channel re-requesting while HELD or DONE is not acknowledged until cleared; no capture, no ack.
- Main FSM:
  - IDLE: when every channel is HELD or DONE (join complete, including the same edge as the last capture), at the next edge load d_o = reduce(op, captured data), register op, busy = 1. Go DELAY, or REQ if T = 0.
  - Reduction is across channels bitwise, N bits, no carries. XNOR is the inverted XOR reduction.
  - DELAY: count T-1 cycles. r_o goes active exactly T edges after the d_o load edge (same edge if T = 0).
  - REQ: r_o active; on synced a_o active, r_o idle, go RTZ.
  - RTZ: wait for synced a_o idle AND all channels DONE. Then clear all channels to EMPTY, busy = 0, go IDLE.
- Capture and ack while the main FSM is not IDLE:
  - Channels still EMPTY never occur outside IDLE, because join requires all captured.
  - A channel in DONE that was cleared may capture a new operand on the edge after the return to IDLE, not on the clear edge.
- d_o is unchanged from load until the next load; no glitching.
- Boundary conditions:
  - Simultaneous arrival of all K requests: all capture on one edge, join completes that edge.
  - Changing op after the load edge has no effect on the current result.
  - Reset mid-operation aborts the transaction. Outputs return to idle levels immediately; partial captures are discarded.

Decomposition:
- Package a_logic_pkg:
  - op encoding enum (OP_XOR, OP_AND, OP_OR, OP_XNOR)
  - channel-state enum (EMPTY, HELD, DONE)
  - main-state enum (IDLE, DELAY, REQ, RTZ)
  - reduction function reduce(op, data)
- Sub-module a_sync: SYNC-stage flop chain with async active-low reset to Rpol. Instantiated K+1 times.

Test Plan:
- K=3, N=8, op=XOR; d_i = 0xA5, 0x3C, 0xFF; simultaneous requests -> d_o = 0x66, r_o active T=2 edges after load, all a_i pulse active then idle.
- op=AND; staggered requests (ch2, then ch0 after 5 cycles, then ch1 after 3 cycles); d_i = 0xF0, 0x3C, 0xFF -> d_o = 0x30 only after ch1 capture. Each a_i rises when its channel is captured.
- During REQ, ch0 raises r_i again with 0x11 -> a_i[0] stays idle until the return to IDLE. Next transaction captures 0x11.
- Rpol=1, T=0, op=XNOR, K=2, N=4; inputs 0x5, 0x3 -> d_o = 0x9, r_o low on the load edge, idle levels high after reset.
- Reset asserted in DELAY -> r_o, a_i at Rpol, d_o = 0, busy = 0 asynchronously. A fresh transaction after release completes normally.
- Slow output ack (a_o held active 20 cycles) plus a channel that holds r_i active past output ack -> FSM stays in RTZ until both are resolved. busy stays 1 throughout.
